// File: rtl/roi_box_overlay.sv
// rtl/roi_box_overlay.sv - rectangular border overlay on a pixel stream, frame-synchronous settings
// Two-stage pipeline: stage 1 registers the hit test, stage 2 selects border colour or video.
module roi_box_overlay #(
    parameter int DATA_WIDTH  = 24,
    parameter int COORD_WIDTH = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_en,
    input  logic [COORD_WIDTH-1:0] cfg_x0,
    input  logic [COORD_WIDTH-1:0] cfg_y0,
    input  logic [COORD_WIDTH-1:0] cfg_x1,
    input  logic [COORD_WIDTH-1:0] cfg_y1,
    input  logic [3:0]             cfg_thick,
    input  logic [DATA_WIDTH-1:0]  cfg_color,
    input  logic                   cfg_blink,
    input  logic                   i_hs,
    input  logic                   i_vs,
    input  logic                   i_de,
    input  logic [DATA_WIDTH-1:0]  i_data,
    input  logic [COORD_WIDTH-1:0] x,
    input  logic [COORD_WIDTH-1:0] y,
    output logic                   o_hs,
    output logic                   o_vs,
    output logic                   o_de,
    output logic [DATA_WIDTH-1:0]  o_data,
    output logic [5:0]             o_frame_cnt,
    output logic                   o_cfg_err
);

    localparam int CW1 = COORD_WIDTH + 1;

    logic                   r_vs_q;
    logic                   r_en;
    logic [COORD_WIDTH-1:0] r_x0, r_y0, r_x1, r_y1;
    logic [3:0]             r_thick;
    logic [DATA_WIDTH-1:0]  r_color;
    logic                   r_blink;
    logic [5:0]             r_frame_cnt;
    logic                   r_cfg_err;

    logic                   r_s1_hs, r_s1_vs, r_s1_de, r_s1_hit;
    logic [DATA_WIDTH-1:0]  r_s1_data, r_s1_color;

    logic                   r_o_hs, r_o_vs, r_o_de;
    logic [DATA_WIDTH-1:0]  r_o_data;

    logic                   w_vs_rise;
    logic [CW1-1:0]         w_x, w_y, w_x0, w_y0, w_x1, w_y1, w_thick;
    logic                   w_inside, w_edge, w_show, w_hit;

    assign w_vs_rise = i_vs & ~r_vs_q;

    // One extra bit keeps x+thick from wrapping when the box touches the last column/row.
    assign w_x     = {1'b0, x};
    assign w_y     = {1'b0, y};
    assign w_x0    = {1'b0, r_x0};
    assign w_y0    = {1'b0, r_y0};
    assign w_x1    = {1'b0, r_x1};
    assign w_y1    = {1'b0, r_y1};
    assign w_thick = {{(CW1-4){1'b0}}, r_thick};

    assign w_inside = (x >= r_x0) & (x <= r_x1) & (y >= r_y0) & (y <= r_y1);
    assign w_edge   = (w_x < (w_x0 + w_thick)) | ((w_x + w_thick) > w_x1) |
                      (w_y < (w_y0 + w_thick)) | ((w_y + w_thick) > w_y1);
    assign w_show   = ~r_blink | ~r_frame_cnt[5];
    assign w_hit    = r_en & ~r_cfg_err & (r_thick != 4'd0) & w_inside & w_edge & w_show;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_q      <= 1'b0;
            r_en        <= 1'b0;
            r_x0        <= '0;
            r_y0        <= '0;
            r_x1        <= '0;
            r_y1        <= '0;
            r_thick     <= '0;
            r_color     <= '0;
            r_blink     <= 1'b0;
            r_frame_cnt <= '0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_vs_q <= i_vs;
            if (w_vs_rise) begin
                r_en        <= cfg_en;
                r_x0        <= cfg_x0;
                r_y0        <= cfg_y0;
                r_x1        <= cfg_x1;
                r_y1        <= cfg_y1;
                r_thick     <= cfg_thick;
                r_color     <= cfg_color;
                r_blink     <= cfg_blink;
                r_frame_cnt <= r_frame_cnt + 6'd1;
                r_cfg_err   <= (cfg_x0 > cfg_x1) | (cfg_y0 > cfg_y1);
            end
        end
    end

    // Colour travels with the hit flag so a pixel never mixes two frames' settings.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_hs    <= 1'b0;
            r_s1_vs    <= 1'b0;
            r_s1_de    <= 1'b0;
            r_s1_hit   <= 1'b0;
            r_s1_data  <= '0;
            r_s1_color <= '0;
            r_o_hs     <= 1'b0;
            r_o_vs     <= 1'b0;
            r_o_de     <= 1'b0;
            r_o_data   <= '0;
        end else begin
            r_s1_hs    <= i_hs;
            r_s1_vs    <= i_vs;
            r_s1_de    <= i_de;
            r_s1_hit   <= w_hit;
            r_s1_data  <= i_data;
            r_s1_color <= r_color;
            r_o_hs     <= r_s1_hs;
            r_o_vs     <= r_s1_vs;
            r_o_de     <= r_s1_de;
            r_o_data   <= (r_s1_hit & r_s1_de) ? r_s1_color : r_s1_data;
        end
    end

    assign o_hs        = r_o_hs;
    assign o_vs        = r_o_vs;
    assign o_de        = r_o_de;
    assign o_data      = r_o_data;
    assign o_frame_cnt = r_frame_cnt;
    assign o_cfg_err   = r_cfg_err;

endmodule
